fp_align_addsub_seq: RTL and testbench
======================================

Name: fp_align_addsub_seq

Overview:
- Parametrised, sequential successor to the single-cycle mantissa align/add stage of the floating-point adder datapath.
- Takes two unpacked operands: sign, exponent, and mantissa with the hidden bit included.
- Orders the operands by magnitude and aligns the smaller one with a multi-cycle right shifter. Guard, round and sticky bits are retained.
- Performs an effective add or subtract and presents an unnormalised result, with a Done/Ack handshake, to the downstream normaliser/rounder.

Parameters:
EXP_W, 8, exponent width in bits
MAN_W, 24, mantissa width including the hidden bit
SHIFT_STEP, 1, maximum right-shift positions applied per ALIGN cycle (1..MAN_W+3)

Ports:
Clk  input  1  clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
Load  input  1  start request; sampled only when Busy=0
Ack  input  1  consumer accepts the result; sampled only when Done=1
S_A  input  1  sign of operand A
S_B  input  1  sign of operand B
E_A  input  EXP_W  exponent of A (biased, unsigned)
E_B  input  EXP_W  exponent of B
M_A  input  MAN_W  mantissa of A
M_B  input  MAN_W  mantissa of B
S_Result  output  1  result sign
E_Result  output  EXP_W  exponent of the larger-magnitude operand
M_Result  output  MAN_W  result mantissa, unnormalised
GRS  output  3  guard, round, sticky bits below M_Result[0]
Carry  output  1  carry-out of an effective add; 0 on subtract
Busy  output  1  1 in ALIGN, ADD and DONE
Done  output  1  result valid; held until Ack

Behaviour:
- Reset is synchronous and active-high, sampled on Clk. It overrides everything, including an operation in progress.
  - State goes to IDLE.
  - All outputs go to 0.
  - Internal operand, shift-count and extended registers are cleared.
- FSM states: IDLE -> ALIGN -> ADD -> DONE -> IDLE.
- IDLE, with Load=1 at the sampling edge, captures the operands:
  - big/small selection: larger exponent wins. On an exponent tie, the larger mantissa wins. On a full tie, A is big.
  - d = E_big - E_small (unsigned, EXP_W bits).
  - big_ext = {M_big, 3'b000} and small_ext = {M_small, 3'b000}, each MAN_W+3 bits.
  - op = S_A ^ S_B (0 = add, 1 = subtract).
  - If d >= MAN_W+3 (saturation): small_ext = {0..0, |M_small} and the remaining count is 0.
  - If remaining == 0 (d == 0 or saturated), next state is ADD; otherwise ALIGN.
- ALIGN, one cycle per step:
  - sh = min(SHIFT_STEP, remaining).
  - small_ext = small_ext >> sh, with the LSB ORed with all bits shifted out (sticky).
  - remaining -= sh. When the result reaches 0, next state is ADD.
- ADD, one cycle, registering the result:
  - op=0: {Carry, M_Result, GRS} = big_ext + small_ext, MAN_W+4 bits.
  - op=1: {M_Result, GRS} = big_ext - small_ext, never negative by construction; Carry = 0.
  - E_Result = E_big.
  - S_Result = S_big, except when op=1 and the difference is 0, where S_Result = 0.
  - Done = 1.
- DONE:
  - Outputs stay stable.
  - Ack=1 -> IDLE and Done = 0 at the same edge.
  - Load is ignored.
- Busy is 0 only in IDLE. Load while Busy=1 is ignored and has no side effects.
- Latency: Load sampled at edge 0 gives k = ceil(d/SHIFT_STEP) ALIGN edges (k = 0 if d == 0 or saturated). ADD results register and Done rises at edge k+1.
- Output values persist in IDLE until the next ADD overwrites them.
- Ack in IDLE, ALIGN or ADD is ignored.
- Exponent specials (0, all-ones) receive no special handling; the caller pre-screens them.

Test Plan:
- MAN_W=24, STEP=1: A = +, E=127, M=0x800000; B = +, E=127, M=0x800000 -> Done after edge 1; Carry=1, M_Result=0x000000, GRS=000, E_Result=127, S_Result=0.
- STEP=1: A = +, E=130, M=0x800000; B = +, E=127, M=0xC00000 -> 3 ALIGN cycles, Done after edge 4; M_Result=0x980000, GRS=000, Carry=0.
- STEP=4: A = +, E=127, M=0x800000; B = +, E=125, M=0x800003 -> Done after edge 2; M_Result=0xA00000, GRS=110.
- Saturation, subtract: A = +, E=127, M=0x800000; B = -, E=100, M=0x800001 -> d=27, Done after edge 1; M_Result=0x7FFFFF, GRS=111, S_Result=0, E_Result=127.
- Ordering and zero sign, both at E=127:
  - A = +, M=0x800000; B = -, M=0xC00000 -> M_Result=0x400000, S_Result=1.
  - A = +1.0, B = -1.0 -> M_Result=0, GRS=000, S_Result=0, Carry=0.
- Handshake and reset:
  - Hold Ack=0 for 5 cycles after Done -> outputs stable, Done held, and a Load pulse is ignored. Ack=1 -> Busy=0 next edge.
  - Separately, d=20 with STEP=1 and Reset asserted at edge 5 -> all outputs 0, Done never rises, and a following Load completes normally.

Source files
------------

// File: rtl/fp_align_addsub_seq.sv
// Sequential mantissa align/add stage: orders operands by magnitude, right-aligns the
// smaller one a few positions per cycle (keeping G/R/S), then adds or subtracts.
module fp_align_addsub_seq #(
  parameter int EXP_W      = 8,
  parameter int MAN_W      = 24,
  parameter int SHIFT_STEP = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Ack,
  input  logic             S_A,
  input  logic             S_B,
  input  logic [EXP_W-1:0] E_A,
  input  logic [EXP_W-1:0] E_B,
  input  logic [MAN_W-1:0] M_A,
  input  logic [MAN_W-1:0] M_B,
  output logic             S_Result,
  output logic [EXP_W-1:0] E_Result,
  output logic [MAN_W-1:0] M_Result,
  output logic [2:0]       GRS,
  output logic             Carry,
  output logic             Busy,
  output logic             Done
);

  localparam int EXT_W = MAN_W + 3;

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

  state_t             state, state_next;
  logic [EXT_W-1:0]   big_ext, small_ext;
  logic [EXP_W-1:0]   remaining;
  logic               op, s_big;
  logic [EXP_W-1:0]   e_big;

  logic               a_big, sat;
  logic [EXP_W-1:0]   d, load_rem, step, remaining_next;
  logic [MAN_W-1:0]   m_small;
  logic [EXT_W-1:0]   load_small, lost_mask, small_shifted;
  logic [EXT_W:0]     sum;
  logic [EXT_W-1:0]   diff;

  // Operand ordering and the initial (possibly saturated) alignment count.
  always_comb begin
    a_big      = (E_A > E_B) || ((E_A == E_B) && (M_A >= M_B));
    d          = a_big ? (E_A - E_B) : (E_B - E_A);
    m_small    = a_big ? M_B : M_A;
    sat        = 32'(d) >= 32'(EXT_W);
    load_small = sat ? EXT_W'(|m_small) : {m_small, 3'b000};
    load_rem   = sat ? '0 : d;
  end

  // One alignment step; bits falling off the bottom collapse into the sticky LSB.
  always_comb begin
    step           = (32'(remaining) < 32'(SHIFT_STEP)) ? remaining : EXP_W'(SHIFT_STEP);
    lost_mask      = ~({EXT_W{1'b1}} << step);
    small_shifted  = (small_ext >> step) | EXT_W'(|(small_ext & lost_mask));
    remaining_next = remaining - step;
    sum            = {1'b0, big_ext} + {1'b0, small_ext};
    diff           = big_ext - small_ext;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Load) state_next = (load_rem == '0) ? ADD : ALIGN;
      ALIGN:   if (remaining_next == '0) state_next = ADD;
      ADD:     state_next = DONE;
      DONE:    if (Ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      big_ext   <= '0;
      small_ext <= '0;
      remaining <= '0;
      op        <= 1'b0;
      s_big     <= 1'b0;
      e_big     <= '0;
      S_Result  <= 1'b0;
      E_Result  <= '0;
      M_Result  <= '0;
      GRS       <= '0;
      Carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Load) begin
          big_ext   <= {(a_big ? M_A : M_B), 3'b000};
          small_ext <= load_small;
          remaining <= load_rem;
          op        <= S_A ^ S_B;
          s_big     <= a_big ? S_A : S_B;
          e_big     <= a_big ? E_A : E_B;
        end
        ALIGN: begin
          small_ext <= small_shifted;
          remaining <= remaining_next;
        end
        ADD: begin
          E_Result <= e_big;
          if (!op) begin
            {Carry, M_Result, GRS} <= sum;
            S_Result               <= s_big;
          end else begin
            {M_Result, GRS} <= diff;
            Carry           <= 1'b0;
            // An exact cancellation always yields +0.
            S_Result        <= (diff == '0) ? 1'b0 : s_big;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_fp_align_addsub_seq.sv
// Randomised and directed bench for fp_align_addsub_seq at SHIFT_STEP=1 and SHIFT_STEP=4,
// checked against an arithmetic reference model.
module tb_fp_align_addsub_seq;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic [2:0]  grs;
    logic        c;
    int          k;
  } res_t;

  logic        clk = 1'b0;
  logic        reset, load, ack, sel;
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  logic        s1, c1, busy1, done1, s4, c4, busy4, done4;
  logic [7:0]  e1, e4;
  logic [23:0] m1, m4;
  logic [2:0]  grs1, grs4;

  logic        cur_s, cur_c, cur_busy, cur_done;
  logic [7:0]  cur_e;
  logic [23:0] cur_m;
  logic [2:0]  cur_grs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_align_addsub_seq #(.EXP_W(8), .MAN_W(24), .SHIFT_STEP(1)) u_step1 (
    .Clk(clk), .Reset(reset), .Load(load && !sel), .Ack(ack && !sel),
    .S_A(sa), .S_B(sb), .E_A(ea), .E_B(eb), .M_A(ma), .M_B(mb),
    .S_Result(s1), .E_Result(e1), .M_Result(m1), .GRS(grs1), .Carry(c1),
    .Busy(busy1), .Done(done1)
  );

  fp_align_addsub_seq #(.EXP_W(8), .MAN_W(24), .SHIFT_STEP(4)) u_step4 (
    .Clk(clk), .Reset(reset), .Load(load && sel), .Ack(ack && sel),
    .S_A(sa), .S_B(sb), .E_A(ea), .E_B(eb), .M_A(ma), .M_B(mb),
    .S_Result(s4), .E_Result(e4), .M_Result(m4), .GRS(grs4), .Carry(c4),
    .Busy(busy4), .Done(done4)
  );

  always_comb begin
    cur_s    = sel ? s4 : s1;
    cur_c    = sel ? c4 : c1;
    cur_busy = sel ? busy4 : busy1;
    cur_done = sel ? done4 : done1;
    cur_e    = sel ? e4 : e1;
    cur_m    = sel ? m4 : m1;
    cur_grs  = sel ? grs4 : grs1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact shift of the smaller mantissa with sticky OR, then plain integer add/sub.
  function automatic res_t ref_model(input int step, input logic a_s, input logic [7:0] a_e,
                                     input logic [23:0] a_m, input logic b_s,
                                     input logic [7:0] b_e, input logic [23:0] b_m);
    res_t   r;
    bit     a_big;
    int     d;
    longint big, sml, lost, v;
    a_big = (a_e > b_e) || ((a_e == b_e) && (a_m >= b_m));
    d     = a_big ? int'(a_e) - int'(b_e) : int'(b_e) - int'(a_e);
    big   = longint'(a_big ? a_m : b_m) * 8;
    sml   = longint'(a_big ? b_m : a_m) * 8;
    if (d >= 27) begin
      sml = (sml != 0) ? 1 : 0;
    end else begin
      lost = sml & ((longint'(1) << d) - 1);
      sml  = sml >> d;
      if (lost != 0) sml = sml | 1;
    end
    if (a_s == b_s) begin
      v   = big + sml;
      r.c = v[27];
      r.s = a_big ? a_s : b_s;
    end else begin
      v   = big - sml;
      r.c = 1'b0;
      r.s = (v == 0) ? 1'b0 : (a_big ? a_s : b_s);
    end
    r.m   = v[26:3];
    r.grs = v[2:0];
    r.e   = a_big ? a_e : b_e;
    r.k   = (d == 0 || d >= 27) ? 0 : (d + step - 1) / step;
    return r;
  endfunction

  // Loads one operation, waits for Done (bounded) and checks latency and results. Leaves Done up.
  task automatic run_op(input logic sel_i, input logic a_s, input logic [7:0] a_e,
                        input logic [23:0] a_m, input logic b_s, input logic [7:0] b_e,
                        input logic [23:0] b_m, output res_t exp);
    int cycles;
    exp = ref_model(sel_i ? 4 : 1, a_s, a_e, a_m, b_s, b_e, b_m);
    @(negedge clk);
    sel = sel_i;
    sa = a_s; ea = a_e; ma = a_m;
    sb = b_s; eb = b_e; mb = b_m;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("busy_after_load", cur_busy, 1'b1);
    cycles = 0;
    while (cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (cur_done) break;
    end
    check("latency", cycles, exp.k + 1);
    check("m_result", cur_m, exp.m);
    check("grs", cur_grs, exp.grs);
    check("carry", cur_c, exp.c);
    check("e_result", cur_e, exp.e);
    check("s_result", cur_s, exp.s);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_busy", cur_busy, 1'b0);
    check("ack_done", cur_done, 1'b0);
  endtask

  initial begin
    res_t exp;
    bit   saw_done;
    int   off;
    reset = 1'b1; load = 1'b0; ack = 1'b0; sel = 1'b0;
    sa = 1'b0; sb = 1'b0; ea = '0; eb = '0; ma = '0; mb = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {busy1, busy4}, 2'b00);
    check("rst_done", {done1, done4}, 2'b00);
    check("rst_m", {m1, m4}, 48'h0);
    check("rst_misc", {s1, c1, e1, grs1, s4, c4, e4, grs4}, 26'h0);

    // 1.0 + 1.0
    run_op(1'b0, 1'b0, 8'd127, 24'h800000, 1'b0, 8'd127, 24'h800000, exp);
    check("tp1_carry", cur_c, 1'b1);
    check("tp1_m", cur_m, 24'h000000);
    do_ack();
    // d=3 at step 1
    run_op(1'b0, 1'b0, 8'd130, 24'h800000, 1'b0, 8'd127, 24'hC00000, exp);
    check("tp2_m", cur_m, 24'h980000);
    do_ack();
    // d=2 at step 4, guard/round set
    run_op(1'b1, 1'b0, 8'd127, 24'h800000, 1'b0, 8'd125, 24'h800003, exp);
    check("tp3_m", cur_m, 24'hA00000);
    check("tp3_grs", cur_grs, 3'b110);
    do_ack();
    // saturated subtract
    run_op(1'b0, 1'b0, 8'd127, 24'h800000, 1'b1, 8'd100, 24'h800001, exp);
    check("tp4_m", cur_m, 24'h7FFFFF);
    check("tp4_grs", cur_grs, 3'b111);
    do_ack();
    // B larger by mantissa only
    run_op(1'b0, 1'b0, 8'd127, 24'h800000, 1'b1, 8'd127, 24'hC00000, exp);
    check("tp5_m", cur_m, 24'h400000);
    check("tp5_s", cur_s, 1'b1);
    do_ack();
    // exact cancellation gives +0
    run_op(1'b1, 1'b0, 8'd127, 24'h800000, 1'b1, 8'd127, 24'h800000, exp);
    check("tp6_m", cur_m, 24'h0);
    check("tp6_s", cur_s, 1'b0);
    do_ack();

    // Done held without Ack; a Load during DONE must be ignored.
    run_op(1'b0, 1'b1, 8'd140, 24'hABCDEF, 1'b0, 8'd133, 24'h912345, exp);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        load = 1'b1; sa = 1'b0; ea = 8'd10; ma = 24'hFFFFFF;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      check("hold_done", cur_done, 1'b1);
      check("hold_m", {cur_s, cur_e, cur_m, cur_grs, cur_c}, {exp.s, exp.e, exp.m, exp.grs, exp.c});
    end
    load = 1'b0;
    do_ack();

    // Reset mid-alignment: d=20, Reset sampled at edge 5.
    @(negedge clk);
    sel = 1'b0; sa = 1'b0; ea = 8'd147; ma = 24'h800000; sb = 1'b0; eb = 8'd127; mb = 24'hFFFFFF;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", cur_busy, 1'b0);
    check("midrst_out", {cur_s, cur_e, cur_m, cur_grs, cur_c, cur_done}, 38'h0);
    saw_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (cur_done) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 1'b0);
    run_op(1'b0, 1'b0, 8'd147, 24'h800000, 1'b0, 8'd127, 24'hFFFFFF, exp);
    do_ack();

    for (int i = 0; i < 60; i++) begin
      logic [7:0]  a_e, b_e;
      logic [23:0] a_m, b_m;
      a_e = 8'(60 + $urandom_range(0, 120));
      off = int'($urandom_range(0, 60)) - 30;
      b_e = 8'(int'(a_e) + off);
      a_m = 24'h800000 | 24'($urandom);
      b_m = 24'h800000 | 24'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        b_e = a_e;
        b_m = a_m;
      end
      run_op(1'(i % 2), 1'($urandom), a_e, a_m, 1'($urandom), b_e, b_m, exp);
      do_ack();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
